dice_player: RTL and testbench

Player-side controller for the dice roller. It debounces the roll and hold buttons and drives the roller's enable while roll is held. On release it latches the settled die value, renders it as a 7-pip LED pattern, and runs a two-player "Pig" game: accumulate turn points, lose them on a 1, bank them on hold, and win on reaching a target. It sits between the board buttons/LEDs and the roller's `ena`/`dice` pins.

---
 rtl/dice_player.sv | 192 +++++++++++++++++++
 tb/tb_dice_player.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dice_player.sv
// Player-side controller: button sync/debounce, roller enable, pip display and two-player Pig scoring.
// Optional DICE_PLAYER_ANIM_EN: pips follow the live die value while rolling.
module dice_player #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TARGET          = 50,
    parameter int SCORE_W         = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               roll_btn,
    input  logic               hold_btn,
    input  logic [2:0]         dice_in,
    output logic               ena_out,
    output logic [6:0]         pips,
    output logic               player,
    output logic [SCORE_W-1:0] turn_total,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               winner_valid,
    output logic               winner,
    output logic               bad_die
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] TARGET_W = SCORE_W'(TARGET);

    typedef enum logic [2:0] {
        S_IDLE, S_ROLLING, S_SETTLE, S_EVAL, S_HOLD, S_GAME_OVER
    } state_t;

    function automatic logic [6:0] pip_map(input logic [2:0] v);
        case (v)
            3'd1:    pip_map = 7'b0001000;
            3'd2:    pip_map = 7'b1000001;
            3'd3:    pip_map = 7'b1001001;
            3'd4:    pip_map = 7'b1100011;
            3'd5:    pip_map = 7'b1101011;
            3'd6:    pip_map = 7'b1110111;
            default: pip_map = 7'b0000000;
        endcase
    endfunction

    // Button index 0 = roll, 1 = hold
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [1:0]    rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    always_comb begin
        sync1_d = {hold_btn, roll_btn};
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) db_d[i] = sync2_q[i];
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    state_t             state_q, state_d;
    logic               ena_q, ena_d, player_q, player_d;
    logic               wvalid_q, wvalid_d, winner_q, winner_d, bad_q, bad_d;
    logic [2:0]         die_q, die_d;
    logic [6:0]         pips_q, pips_d;
    logic [SCORE_W-1:0] turn_q, turn_d, score0_q, score0_d, score1_q, score1_d;
    logic [SCORE_W-1:0] cur_score, new_turn, total;

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        wvalid_d  = wvalid_q;
        winner_d  = winner_q;
        bad_d     = 1'b0;
        die_d     = die_q;
        pips_d    = pips_q;
        turn_d    = turn_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        cur_score = player_q ? score1_q : score0_q;
        new_turn  = turn_q + SCORE_W'(die_q);
        total     = cur_score + new_turn;
        case (state_q)
            S_IDLE: begin
                if (rise_q[0])                           state_d = S_ROLLING;
                else if (rise_q[1] && turn_q != '0)      state_d = S_HOLD;
            end
            S_ROLLING: begin
`ifdef DICE_PLAYER_ANIM_EN
                pips_d = pip_map(dice_in);
`endif
                if (fall_q[0]) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                die_d   = dice_in;
                pips_d  = pip_map(dice_in);
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_IDLE;
                if (die_q == 3'd0 || die_q == 3'd7) begin
                    bad_d = 1'b1;
                end else if (die_q == 3'd1) begin
                    turn_d   = '0;
                    player_d = ~player_q;
                end else if (total >= TARGET_W) begin
                    if (player_q) score1_d = total;
                    else          score0_d = total;
                    turn_d   = '0;
                    winner_d = player_q;
                    wvalid_d = 1'b1;
                    state_d  = S_GAME_OVER;
                end else begin
                    turn_d = new_turn;
                end
            end
            S_HOLD: begin
                if (player_q) score1_d = score1_q + turn_q;
                else          score0_d = score0_q + turn_q;
                turn_d   = '0;
                player_d = ~player_q;
                state_d  = S_IDLE;
            end
            S_GAME_OVER: begin
                if (rise_q[0]) begin
                    score0_d = '0;
                    score1_d = '0;
                    turn_d   = '0;
                    player_d = 1'b0;
                    wvalid_d = 1'b0;
                    pips_d   = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ena_d = (state_d == S_ROLLING);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
            state_q  <= S_IDLE;
            ena_q    <= 1'b0;
            player_q <= 1'b0;
            wvalid_q <= 1'b0;
            winner_q <= 1'b0;
            bad_q    <= 1'b0;
            die_q    <= '0;
            pips_q   <= '0;
            turn_q   <= '0;
            score0_q <= '0;
            score1_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
            state_q  <= state_d;
            ena_q    <= ena_d;
            player_q <= player_d;
            wvalid_q <= wvalid_d;
            winner_q <= winner_d;
            bad_q    <= bad_d;
            die_q    <= die_d;
            pips_q   <= pips_d;
            turn_q   <= turn_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
        end
    end

    assign ena_out      = ena_q;
    assign pips         = pips_q;
    assign player       = player_q;
    assign turn_total   = turn_q;
    assign score0       = score0_q;
    assign score1       = score1_q;
    assign winner_valid = wvalid_q;
    assign winner       = winner_q;
    assign bad_die      = bad_q;
endmodule

// File: tb/tb_dice_player.sv
// Directed self-checking bench for dice_player with DEBOUNCE_CYCLES=4, TARGET=20.
module tb_dice_player;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       roll_btn, hold_btn;
    logic [2:0] dice_in;
    logic       ena_out, player, winner_valid, winner, bad_die;
    logic [6:0] pips;
    logic [6:0] turn_total, score0, score1;

    int checks = 0;
    int errors = 0;
    int ena_cnt, first, bad_cnt;

    always #5 clk = ~clk;

    dice_player #(.DEBOUNCE_CYCLES(4), .TARGET(20), .SCORE_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .roll_btn(roll_btn), .hold_btn(hold_btn),
        .dice_in(dice_in), .ena_out(ena_out), .pips(pips), .player(player),
        .turn_total(turn_total), .score0(score0), .score1(score1),
        .winner_valid(winner_valid), .winner(winner), .bad_die(bad_die)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press roll for n cycles (optionally with hold), release, then let the FSM finish.
    task automatic do_roll(input int n, input logic [2:0] die, input logic with_hold,
                           output int ecnt, output int efirst, output int bcnt);
        dice_in  = die;
        roll_btn = 1'b1;
        hold_btn = with_hold;
        ecnt = 0; efirst = -1; bcnt = 0;
        for (int i = 1; i <= n + 20; i++) begin
            if (i == n + 1) begin
                roll_btn = 1'b0;
                hold_btn = 1'b0;
            end
            @(negedge clk);
            if (ena_out === 1'b1) begin
                ecnt++;
                if (efirst < 0) efirst = i;
            end
            if (bad_die === 1'b1) bcnt++;
        end
    endtask

    task automatic do_hold();
        hold_btn = 1'b1;
        repeat (8) @(negedge clk);
        hold_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; roll_btn = 1'b0; hold_btn = 1'b0; dice_in = 3'd0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ena", ena_out, 0);
        check("rst_pips", pips, 0);
        check("rst_player", player, 0);
        check("rst_score0", score0, 0);
        check("rst_score1", score1, 0);
        check("rst_turn", turn_total, 0);
        check("rst_wvalid", winner_valid, 0);

        // 3-cycle bounce must not pass the debouncer
        roll_btn = 1'b1;
        ena_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) roll_btn = 1'b0;
            @(negedge clk);
            if (ena_out === 1'b1) ena_cnt++;
        end
        check("bounce_ena", ena_cnt, 0);

        do_roll(10, 3'd5, 1'b0, ena_cnt, first, bad_cnt);
        check("r5_ena_len", ena_cnt, 10);
        check("r5_latency", first, 7);
        check("r5_pips", pips, 7'b1101011);
        check("r5_turn", turn_total, 5);
        check("r5_player", player, 0);

        do_roll(10, 3'd4, 1'b0, ena_cnt, first, bad_cnt);
        check("r4_turn", turn_total, 9);
        do_roll(10, 3'd1, 1'b0, ena_cnt, first, bad_cnt);
        check("r1_turn", turn_total, 0);
        check("r1_player", player, 1);
        check("r1_score0", score0, 0);
        check("r1_pips", pips, 7'b0001000);
        do_hold();
        check("h0_player", player, 1);
        check("h0_score1", score1, 0);
        check("h0_score0", score0, 0);

        do_roll(10, 3'd1, 1'b0, ena_cnt, first, bad_cnt);
        check("p1_r1_player", player, 0);
        do_roll(10, 3'd5, 1'b0, ena_cnt, first, bad_cnt);
        do_roll(10, 3'd4, 1'b0, ena_cnt, first, bad_cnt);
        check("pre_hold_turn", turn_total, 9);
        do_hold();
        check("hold_score0", score0, 9);
        check("hold_player", player, 1);
        check("hold_turn", turn_total, 0);

        // Roll and hold rising together: roll wins, hold dropped
        do_roll(10, 3'd3, 1'b1, ena_cnt, first, bad_cnt);
        check("both_ena_len", ena_cnt, 10);
        check("both_turn", turn_total, 3);
        check("both_score1", score1, 0);
        check("both_player", player, 1);

        do_roll(10, 3'd0, 1'b0, ena_cnt, first, bad_cnt);
        check("bad_pulse", bad_cnt, 1);
        check("bad_pips", pips, 0);
        check("bad_turn", turn_total, 3);
        check("bad_score0", score0, 9);
        check("bad_score1", score1, 0);

        do_hold();
        check("h1_score1", score1, 3);
        check("h1_player", player, 0);
        do_roll(10, 3'd5, 1'b0, ena_cnt, first, bad_cnt);
        do_roll(10, 3'd2, 1'b0, ena_cnt, first, bad_cnt);
        do_hold();
        check("pre_win_score0", score0, 16);
        do_roll(10, 3'd1, 1'b0, ena_cnt, first, bad_cnt);
        check("pre_win_player", player, 0);
        check("pre_win_wvalid", winner_valid, 0);

        do_roll(10, 3'd4, 1'b0, ena_cnt, first, bad_cnt);
        check("win_score0", score0, 20);
        check("win_wvalid", winner_valid, 1);
        check("win_winner", winner, 0);
        check("win_turn", turn_total, 0);
        check("win_pips", pips, 7'b1100011);
        do_hold();
        check("go_hold_score0", score0, 20);
        check("go_hold_wvalid", winner_valid, 1);

        do_roll(10, 3'd6, 1'b0, ena_cnt, first, bad_cnt);
        check("clr_no_roll", ena_cnt, 0);
        check("clr_score0", score0, 0);
        check("clr_score1", score1, 0);
        check("clr_wvalid", winner_valid, 0);
        check("clr_pips", pips, 0);
        check("clr_player", player, 0);

        do_roll(10, 3'd6, 1'b0, ena_cnt, first, bad_cnt);
        check("new_ena_len", ena_cnt, 10);
        check("new_pips", pips, 7'b1110111);
        check("new_turn", turn_total, 6);

        // Reset in the middle of a roll
        roll_btn = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_ena", ena_out, 1);
        reset_n = 1'b0;
        @(negedge clk);
        roll_btn = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ena", ena_out, 0);
        check("mid_rst_turn", turn_total, 0);
        check("mid_rst_pips", pips, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
